// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: owns the PC, one outstanding imem request, instruction register
module instr_fetch #(
    parameter int              N           = 32,
    parameter int              INSTR_WIDTH = 32,
    parameter logic [N-1:0]    RESET_PC    = 32'h0000_0000,
    parameter logic [INSTR_WIDTH-1:0] NOP  = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [N-1:0]           imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [N-1:0]           redirect_pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [N-1:0]           pc,
    output logic                   instr_valid,
    output logic                   ctrl_override
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             fetch_pc_q, fetch_pc_d;
    logic                     discard_q, discard_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [N-1:0]             pc_q, pc_d;
    logic                     valid_q, valid_d;

    logic                     req;
    logic                     accept;
    logic                     load;
    logic                     unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A valid instruction held under stall suppresses new requests.
    assign req    = (state_q == S_FETCH) && !(valid_q && stall);
    assign accept = req && imem_gnt;
    assign load   = (state_q == S_WAIT) && imem_rvalid && !discard_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        if (redirect) begin
            instr_d    = NOP;
            valid_d    = 1'b0;
            fetch_pc_d = {redirect_pc[N-1:2], 2'b00};
            // An in-flight request must have its late response dropped.
            if (((state_q == S_WAIT) && !imem_rvalid) || accept) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = S_FETCH;
                discard_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_FETCH;
                        end else begin
                            state_d = stall ? S_HOLD : S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase

            if (load) begin
                instr_d    = imem_rdata;
                pc_d       = fetch_pc_q;
                valid_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + N'(4);
            end else if (valid_q && !stall) begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req      = req;
    assign imem_addr     = fetch_pc_q;
    assign instr         = instr_q;
    assign pc            = pc_q;
    assign instr_valid   = valid_q;
    assign ctrl_override = ~valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scenarios plus randomized run against a transaction-level model
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req, instr_valid, ctrl_override;
    logic [31:0] imem_addr, instr, pc;
    logic        w_req, w_valid, w_ovr;
    logic [31:0] w_addr, w_instr, w_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // transaction-level reference state
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_fetch, m_pend;
    logic        m_outst, m_drop;
    int          n_deliv;

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .ctrl_override(ctrl_override)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(w_instr), .pc(w_pc), .instr_valid(w_valid), .ctrl_override(w_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic st, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall       = st;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        m_valid = 1'b0; m_instr = NOP; m_pc = 32'h0; m_fetch = 32'h0;
        m_outst = 1'b0; m_drop = 1'b0; m_pend = 32'h0;
    endtask

    initial begin
        logic accept, deliver;
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        n_deliv = 0;

        // reset state and first fetch
        reset_dut();
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_ovr", {31'b0, ctrl_override}, 32'd1);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        check("t1_req", {31'b0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        step(0, 1, 32'h0050_0093, 0, 0, 0);
        check("t1_wait_req", {31'b0, imem_req}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        check("t1_instr", instr, 32'h0050_0093);
        check("t1_pc", pc, 32'h0);
        check("t1_valid", {31'b0, instr_valid}, 32'd1);
        check("t1_ovr", {31'b0, ctrl_override}, 32'd0);
        check("t1_next_addr", imem_addr, 32'h4);

        // stall while valid
        step(0, 1, 32'hDEAD_0001, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 0);
            check("t2_instr", instr, 32'hDEAD_0001);
            check("t2_pc", pc, 32'h4);
            check("t2_valid", {31'b0, instr_valid}, 32'd1);
            check("t2_req", {31'b0, imem_req}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0);
        check("t2_release_valid", {31'b0, instr_valid}, 32'd1);

        // gnt withheld
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("t3_req", {31'b0, imem_req}, 32'd1);
            check("t3_addr", imem_addr, 32'h8);
            check("t3_valid", {31'b0, instr_valid}, 32'd0);
        end
        step(1, 0, 0, 0, 0, 0);
        check("t3_gnt_addr", imem_addr, 32'h8);

        // redirect during WAIT drops the late response
        step(0, 0, 0, 0, 1, 32'h0000_0103);
        check("t4_wait_req", {31'b0, imem_req}, 32'd0);
        step(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
        check("t4_discard_req", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("t4_valid", {31'b0, instr_valid}, 32'd0);
        check("t4_instr", instr, NOP);
        check("t4_req", {31'b0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h0000_0100);

        // reset during WAIT, stale response afterwards
        step(1, 0, 0, 0, 0, 0);
        check("t6_accept_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        step(0, 0, 0, 0, 0, 0);
        check("t6_valid", {31'b0, instr_valid}, 32'd0);
        check("t6_instr", instr, NOP);
        check("t6_req", {31'b0, imem_req}, 32'd1);
        check("t6_addr", imem_addr, 32'h0);

        // PC wrap-around on the high-reset-PC instance
        reset_dut();
        step(1, 0, 0, 0, 0, 0);
        check("t5_req", {31'b0, w_req}, 32'd1);
        check("t5_addr0", w_addr, 32'hFFFF_FFFC);
        step(0, 1, 32'h1111_0001, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("t5_instr0", w_instr, 32'h1111_0001);
        check("t5_pc0", w_pc, 32'hFFFF_FFFC);
        check("t5_addr1", w_addr, 32'h0);
        step(0, 1, 32'h2222_0002, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t5_instr1", w_instr, 32'h2222_0002);
        check("t5_pc1", w_pc, 32'h0);
        check("t5_valid1", {31'b0, w_valid}, 32'd1);
        check("t5_ovr1", {31'b0, w_ovr}, 32'd0);

        // randomized run against the transaction model
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            imem_gnt    = $urandom_range(0, 1) == 1;
            imem_rvalid = m_outst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            imem_rdata  = (m_outst && imem_rvalid) ? mem_word(m_pend) : $urandom;
            #1;
            check("r_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("r_ovr", {31'b0, ctrl_override}, {31'b0, ~m_valid});
            check("r_instr", instr, m_instr);
            check("r_pc", pc, m_pc);
            if (imem_req) check("r_addr", imem_addr, m_fetch);
            if (m_outst || (m_valid && stall)) check("r_no_req", {31'b0, imem_req}, 32'd0);

            accept  = imem_req && imem_gnt;
            deliver = m_outst && imem_rvalid;
            if (redirect) begin
                m_valid = 1'b0;
                m_instr = NOP;
                m_fetch = {redirect_pc[31:2], 2'b00};
            end else if (deliver && !m_drop) begin
                m_valid = 1'b1;
                m_instr = mem_word(m_pend);
                m_pc    = m_pend;
                m_fetch = m_pend + 32'd4;
                n_deliv++;
            end else if (m_valid && !stall) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
            if (deliver) begin
                m_outst = 1'b0;
                m_drop  = 1'b0;
            end else if (m_outst && redirect) begin
                m_drop = 1'b1;
            end
            if (accept) begin
                m_outst = 1'b1;
                m_pend  = imem_addr;
                m_drop  = redirect;
            end
        end
        check("r_progress", {31'b0, n_deliv > 200}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
